// File: rtl/dmem_responder.sv
// Memory-side responder of the CPU data bus: zero-cleared on-chip RAM with
// byte-lane writes and one-cycle registered read-first reads. Optional DMEM_PARITY_EN.
module dmem_responder #(
  parameter int unsigned AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Zz_addr,
  input  logic [31:0] Zz_dout,
  input  logic [3:0]  Zz_wr_en,
  output logic [31:0] zZ_din,
  output logic        mem_busy,
  output logic        par_err
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] idx;
  logic          sel;
  logic [31:0]   rd_word;
  logic          rd_perr;
  logic          unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign idx              = Zz_addr[AW+1:2];
  assign sel              = ~Zz_addr[31];
  assign rd_word          = mem[idx];
  // High in-region bits alias and the byte offset is irrelevant to lane selection.
  assign unused_addr_bits = ^{Zz_addr[30:AW+2], Zz_addr[1:0]};

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (sel) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (Zz_wr_en[i]) mem[idx][8*i +: 8] <= Zz_dout[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] rd_par;
  logic [3:0] wr_par;

  assign rd_par = par_mem[idx];

  always_comb begin
    wr_par  = '0;
    rd_perr = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      wr_par[i] = ^Zz_dout[8*i +: 8];
      rd_perr   = rd_perr | (^rd_word[8*i +: 8] ^ rd_par[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par_mem[clr_cnt] <= '0;
    end else if (sel) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (Zz_wr_en[i]) par_mem[idx][i] <= wr_par[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       par_err <= 1'b0;
    else if (state == READY && sel) par_err <= rd_perr;
    else                           par_err <= 1'b0;
  end
`else
  assign rd_perr = 1'b0;
  assign par_err = rd_perr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      zZ_din   <= '0;
      mem_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          zZ_din   <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state    <= READY;
            mem_busy <= 1'b0;
          end else begin
            mem_busy <= 1'b1;
          end
        end
        default: begin
          mem_busy <= 1'b0;
          zZ_din   <= sel ? rd_word : '0;
        end
      endcase
    end
  end

endmodule
